ysyx_ifu_axi_rd: RTL and testbench

// - Upstream bus stage of the IFU: turns the IFU L1I refill request into AXI4 read bursts.
//   It returns the selected 32-bit words to the IFU refill FSM.
// - Sits between the IFU fetch port and the SoC xbar/arbiter (AR/R channels only).
// - SDRAM-window addresses use one 2-beat INCR burst; all other addresses use single beats.

---
 rtl/ysyx_ifu_axi_rd_pkg.sv | 14 +
 rtl/ysyx_ifu_axi_rd_if.sv | 29 ++
 rtl/ysyx_ifu_axi_rd.sv | 139 +++++++++++++
 tb/tb_ysyx_ifu_axi_rd.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_ifu_axi_rd_pkg.sv
// Shared AXI encodings and FSM state constants for the IFU AXI read stage.
package ysyx_ifu_axi_rd_pkg;

    localparam logic [1:0] YSYX_AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] YSYX_AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] YSYX_AXI_RESP_OKAY  = 2'b00;

    typedef logic [1:0] ysyx_ifu_rd_state_t;

    localparam ysyx_ifu_rd_state_t ST_IDLE = 2'd0;
    localparam ysyx_ifu_rd_state_t ST_AR   = 2'd1;
    localparam ysyx_ifu_rd_state_t ST_R    = 2'd2;

endpackage

// File: rtl/ysyx_ifu_axi_rd_if.sv
// AXI4 read-address and read-data channels between the IFU read stage and the xbar.
interface ysyx_ifu_axi_rd_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AXI_DW = 64
);
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [AXI_DW-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [3:0]        rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_ifu_axi_rd.sv
// IFU refill read stage: turns one IFU word request into an AXI4 single or 2-beat INCR read.
module ysyx_ifu_axi_rd
    import ysyx_ifu_axi_rd_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       AXI_DW   = 64,
    parameter bit                BURST_EN = 1'b1,
    parameter logic [DATA_W-1:0] BURST_LO = 'ha0000000,
    parameter logic [DATA_W-1:0] BURST_HI = 'hc0000000,
    parameter logic [3:0]        AXI_ID   = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  ifu_araddr_i,
    input  logic               ifu_arvalid_i,
    input  logic               ifu_required_i,
    output logic [DATA_W-1:0]  ifu_rdata_o,
    output logic               ifu_rvalid_o,
    output logic               ifu_burst_o,
    output logic               bus_err_o,
    ysyx_ifu_axi_rd_if.master  axi
);

    localparam int unsigned LANE_W = $clog2(AXI_DW / DATA_W);

    ysyx_ifu_rd_state_t r_state;
    ysyx_ifu_rd_state_t w_state_nxt;

    logic [DATA_W-1:0] r_addr;
    logic              r_burst;
    logic              r_beat;
    logic              r_drop;
    logic              r_err;

    logic              w_in_win;
    logic              w_beat_acc;
    logic              w_last;
    logic [LANE_W-1:0] w_lane;
    logic [DATA_W-1:0] w_word;
    logic              w_unused_rid;

    assign w_in_win = BURST_EN && (ifu_araddr_i >= BURST_LO) && (ifu_araddr_i <= BURST_HI);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and beat bookkeeping; a burst ends on its second accepted beat
    always_comb begin
        w_state_nxt = r_state;
        w_beat_acc  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ifu_arvalid_i) begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                if (axi.rvalid) begin
                    w_beat_acc = 1'b1;
                    if (!r_burst || r_beat) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, beat counter, drop flag and sticky bus error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_burst <= 1'b0;
            r_beat  <= 1'b0;
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && ifu_arvalid_i) begin
                r_addr  <= ifu_araddr_i;
                r_burst <= w_in_win;
            end else if (w_beat_acc && w_last) begin
                r_burst <= 1'b0;
            end

            if (r_state == ST_AR) begin
                r_beat <= 1'b0;
            end else if (w_beat_acc) begin
                r_beat <= ~w_last;
            end

            if (w_beat_acc && w_last) begin
                r_drop <= 1'b0;
            end else if (r_state != ST_IDLE && !ifu_required_i) begin
                r_drop <= 1'b1;
            end

            if (w_beat_acc && ((axi.rresp != YSYX_AXI_RESP_OKAY) || (axi.rlast != w_last))) begin
                r_err <= 1'b1;
            end
        end
    end

    // AR channel: fields come straight from the latched request so they stay stable while waiting
    assign axi.arvalid = (r_state == ST_AR);
    assign axi.araddr  = r_burst ? (r_addr & ~DATA_W'(4)) : r_addr;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = r_burst ? 8'd1 : 8'd0;
    assign axi.arsize  = YSYX_AXI_SIZE_4B;
    assign axi.arburst = YSYX_AXI_BURST_INCR;
    assign axi.rready  = (r_state == ST_R);

    // Lane mux: bursts walk lanes in beat order, single beats follow the address
    assign w_lane = r_burst ? LANE_W'(r_beat) : r_addr[2 +: LANE_W];
    assign w_word = axi.rdata[w_lane * DATA_W +: DATA_W];

    assign ifu_rvalid_o = (r_state == ST_R) && axi.rvalid && !r_drop;
    assign ifu_rdata_o  = ifu_rvalid_o ? w_word : '0;
    assign ifu_burst_o  = r_burst;
    assign bus_err_o    = r_err;

    // Only one transaction is ever outstanding, so the returned id carries no information
    assign w_unused_rid = ^axi.rid;

endmodule

// File: tb/tb_ysyx_ifu_axi_rd.sv
// Self-checking bench for ysyx_ifu_axi_rd: directed table, reset corner case, random transactions.
module tb_ysyx_ifu_axi_rd;

    localparam logic [31:0] LO = 32'ha0000000;
    localparam logic [31:0] HI = 32'hc0000000;

    typedef struct {
        logic [31:0] addr;
        int          ar_dly;
        int          gap;
        logic [1:0]  resp;
        bit          wrong_last;
        int          drop_mode;   // 0 none, 1 required falls in AR, 2 required falls in R (gap>=1)
        logic [63:0] d0;
        logic [63:0] d1;
        logic [31:0] e_araddr;
        logic [7:0]  e_len;
        bit          e_burst;
        logic [31:0] e_w0;
        logic [31:0] e_w1;
        bit          e_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr_i;
    logic        ifu_arvalid_i;
    logic        ifu_required_i;
    logic [31:0] ifu_rdata_o;
    logic        ifu_rvalid_o;
    logic        ifu_burst_o;
    logic        bus_err_o;

    int n_chk;
    int n_pass;
    bit err_model;

    ysyx_ifu_axi_rd_if #(.DATA_W(32), .AXI_DW(64)) axi ();

    ysyx_ifu_axi_rd dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_araddr_i   (ifu_araddr_i),
        .ifu_arvalid_i  (ifu_arvalid_i),
        .ifu_required_i (ifu_required_i),
        .ifu_rdata_o    (ifu_rdata_o),
        .ifu_rvalid_o   (ifu_rvalid_o),
        .ifu_burst_o    (ifu_burst_o),
        .bus_err_o      (bus_err_o),
        .axi            (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input int ar_dly, input int gap,
                                input logic [1:0] resp, input bit wl, input int dm,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [31:0] ea, input logic [7:0] el, input bit eb,
                                input logic [31:0] w0, input logic [31:0] w1, input bit ee);
        vec_t v;
        v.addr = addr; v.ar_dly = ar_dly; v.gap = gap; v.resp = resp; v.wrong_last = wl;
        v.drop_mode = dm; v.d0 = d0; v.d1 = d1; v.e_araddr = ea; v.e_len = el; v.e_burst = eb;
        v.e_w0 = w0; v.e_w1 = w1; v.e_err = ee;
        return v;
    endfunction

    // Reference model: AXI INCR beat k lives at start+4k; its word sits in lane (beat_addr/4)%2
    function automatic vec_t model(input vec_t v, input bit err_before);
        vec_t        r;
        logic [31:0] ba;
        logic [63:0] d;
        r = v;
        r.e_burst  = (v.addr >= LO) && (v.addr <= HI);
        r.e_araddr = r.e_burst ? (v.addr / 8) * 8 : v.addr;
        r.e_len    = r.e_burst ? 8'd1 : 8'd0;
        for (int k = 0; k < 2; k++) begin
            ba = r.e_araddr + 32'(4 * k);
            d  = (k == 0) ? v.d0 : v.d1;
            if (k == 0) r.e_w0 = 32'(d >> (32 * ((ba / 4) % 2)));
            else        r.e_w1 = 32'(d >> (32 * ((ba / 4) % 2)));
        end
        r.e_err = err_before || (v.resp != 2'b00) || v.wrong_last;
        return r;
    endfunction

    function automatic vec_t gen_rand();
        vec_t        v;
        logic [31:0] edges [4];
        edges[0] = LO - 32'd4; edges[1] = LO; edges[2] = HI; edges[3] = HI + 32'd4;
        case ($urandom_range(0, 2))
            0:       v.addr = LO + 32'($urandom_range(0, 32'h08000000)) * 32'd4;
            1:       v.addr = $urandom & ~32'd3;
            default: v.addr = edges[$urandom_range(0, 3)];
        endcase
        v.ar_dly     = $urandom_range(0, 3);
        v.gap        = $urandom_range(0, 2);
        v.resp       = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
        v.wrong_last = ($urandom_range(0, 15) == 0);
        v.drop_mode  = 0;
        if ($urandom_range(0, 5) == 0) v.drop_mode = 1;
        else if ($urandom_range(0, 5) == 0 && v.gap >= 1) v.drop_mode = 2;
        v.d0 = {$urandom, $urandom};
        v.d1 = {$urandom, $urandom};
        return v;
    endfunction

    // Drives one IFU request and plays the AXI slave, checking every cycle of it
    task automatic run_txn(input vec_t v, input string tag);
        int nb;
        bit drop;
        int pulses;
        nb     = v.e_burst ? 2 : 1;
        drop   = 1'b0;
        pulses = 0;
        ifu_arvalid_i  = 1'b1;
        ifu_araddr_i   = v.addr;
        ifu_required_i = 1'b1;
        #4;
        chk({tag, " issue_latency_arvalid"}, 64'(axi.arvalid), 64'd0);
        step();
        for (int d = 0; d <= v.ar_dly; d++) begin
            ifu_araddr_i = $urandom;
            axi.arready  = (d == v.ar_dly);
            if (v.drop_mode == 1 && d == 0) begin
                ifu_required_i = 1'b0;
                drop = 1'b1;
            end
            #4;
            chk({tag, " arvalid"}, 64'(axi.arvalid), 64'd1);
            chk({tag, " araddr"},  64'(axi.araddr),  64'(v.e_araddr));
            chk({tag, " arlen"},   64'(axi.arlen),   64'(v.e_len));
            chk({tag, " ar_misc"}, 64'({axi.arid, axi.arsize, axi.arburst}), 64'({4'h0, 3'b010, 2'b01}));
            chk({tag, " burst_o"}, 64'(ifu_burst_o), 64'(v.e_burst));
            step();
        end
        axi.arready = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                axi.rvalid = 1'b0;
                axi.rdata  = {$urandom, $urandom};
                if (v.drop_mode == 2 && k == 0 && g == 0) begin
                    ifu_required_i = 1'b0;
                    drop = 1'b1;
                end
                #4;
                chk({tag, " gap_rready"}, 64'(axi.rready), 64'd1);
                chk({tag, " gap_out"}, 64'({ifu_rvalid_o, ifu_rdata_o, axi.arvalid}), 64'd0);
                step();
            end
            axi.rvalid = 1'b1;
            axi.rdata  = (k == 0) ? v.d0 : v.d1;
            axi.rresp  = v.resp;
            axi.rlast  = (k == nb - 1) ^ (v.wrong_last && k == 0);
            #4;
            chk({tag, " beat_rready"}, 64'(axi.rready), 64'd1);
            chk({tag, " beat_rvalid"}, 64'(ifu_rvalid_o), 64'(!drop));
            chk({tag, " beat_rdata"}, 64'(ifu_rdata_o), drop ? 64'd0 : 64'((k == 0) ? v.e_w0 : v.e_w1));
            chk({tag, " beat_burst_o"}, 64'(ifu_burst_o), 64'(v.e_burst));
            if (ifu_rvalid_o) pulses++;
            step();
        end
        axi.rvalid     = 1'b0;
        axi.rlast      = 1'b0;
        axi.rresp      = 2'b00;
        ifu_arvalid_i  = 1'b0;
        ifu_required_i = 1'b1;
        #4;
        chk({tag, " pulses"}, 64'(pulses), drop ? 64'd0 : 64'(nb));
        chk({tag, " no_reissue"}, 64'({axi.arvalid, axi.rready, ifu_burst_o}), 64'd0);
        chk({tag, " bus_err"}, 64'(bus_err_o), 64'(v.e_err));
        step();
    endtask

    vec_t tbl [11];
    vec_t rv;

    initial begin
        n_chk = 0; n_pass = 0; err_model = 1'b0;
        rst = 1'b0;
        ifu_araddr_i = '0; ifu_arvalid_i = 1'b0; ifu_required_i = 1'b1;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
        axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 4'h0;

        //          addr          ard gap resp wl dm d0                      d1                      e_araddr      len eb w0            w1            err
        tbl[0]  = mk(32'h30000004, 2, 0, 2'b00, 0, 0, 64'h1111_2222_0000_0013, 64'h0,                 32'h30000004, 0, 0, 32'h11112222, 32'h0,        0);
        tbl[1]  = mk(32'ha0000004, 0, 0, 2'b00, 0, 0, 64'hdead_beef_0000_0513, 64'h0010_0093_cafe_f00d, 32'ha0000000, 1, 1, 32'h00000513, 32'h00100093, 0);
        tbl[2]  = mk(32'hbffffffc, 5, 2, 2'b00, 0, 0, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 32'hbffffff8, 1, 1, 32'h89abcdef, 32'hfedcba98, 0);
        tbl[3]  = mk(32'hc0000000, 1, 1, 2'b00, 0, 0, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc, 32'hc0000000, 1, 1, 32'h77778888, 32'h9999aaaa, 0);
        tbl[4]  = mk(32'hc0000004, 0, 0, 2'b00, 0, 0, 64'h1234_5678_0000_0000, 64'h0,                 32'hc0000004, 0, 0, 32'h12345678, 32'h0,        0);
        tbl[5]  = mk(32'h9ffffffc, 0, 1, 2'b00, 0, 0, 64'haaaa_bbbb_cccc_dddd, 64'h0,                 32'h9ffffffc, 0, 0, 32'haaaabbbb, 32'h0,        0);
        tbl[6]  = mk(32'h80000000, 1, 0, 2'b00, 0, 0, 64'haaaa_bbbb_cccc_dddd, 64'h0,                 32'h80000000, 0, 0, 32'hccccdddd, 32'h0,        0);
        tbl[7]  = mk(32'ha0000010, 0, 1, 2'b00, 0, 2, 64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444, 32'ha0000010, 1, 1, 32'h22222222, 32'h33333333, 0);
        tbl[8]  = mk(32'h30000000, 0, 0, 2'b00, 0, 0, 64'h7777_0000_0000_0093, 64'h0,                 32'h30000000, 0, 0, 32'h00000093, 32'h0,        0);
        tbl[9]  = mk(32'h30000008, 0, 0, 2'b10, 0, 0, 64'h0bad_0bad_1234_abcd, 64'h0,                 32'h30000008, 0, 0, 32'h1234abcd, 32'h0,        1);
        tbl[10] = mk(32'ha0000020, 0, 0, 2'b00, 1, 0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 32'ha0000020, 1, 1, 32'h00000002, 32'h00000003, 1);

        #3;
        chk("reset_outputs", 64'({axi.arvalid, axi.rready, ifu_rvalid_o, ifu_burst_o, bus_err_o}), 64'd0);
        chk("reset_rdata", 64'(ifu_rdata_o), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Async reset while the first burst beat is on the bus
        ifu_arvalid_i = 1'b1;
        ifu_araddr_i  = 32'ha0000008;
        step();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 64'h1234_5678_9abc_def0;
        #4;
        chk("pre_reset_rvalid", 64'(ifu_rvalid_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({axi.arvalid, axi.rready, ifu_rvalid_o, ifu_burst_o, bus_err_o}), 64'd0);
        chk("async_reset_rdata", 64'(ifu_rdata_o), 64'd0);
        axi.rvalid    = 1'b0;
        ifu_arvalid_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        err_model = 1'b0;
        rv = gen_rand();
        rv.addr = 32'h30000004; rv.resp = 2'b00; rv.wrong_last = 0; rv.drop_mode = 0;
        rv = model(rv, err_model);
        run_txn(rv, "post_reset");

        for (int n = 0; n < 60; n++) begin
            rv = model(gen_rand(), err_model);
            err_model = rv.e_err;
            run_txn(rv, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
